// File: rtl/sensor_pkg.sv
// Shared types and constants for the sensor monitor: FSM state encoding,
// counter widths and the sensor error-pattern decode.
package sensor_pkg;

    localparam int FAULT_CNT_W = 8;
    localparam int DBNC_CNT_W  = 4;

    localparam logic [FAULT_CNT_W-1:0] FAULT_MAX = '1;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        MONITOR = 2'd1,
        PENDING = 2'd2,
        ALARM   = 2'd3
    } state_t;

    // Sensor 0 alone is fatal; sensor 1 is only an error when corroborated by 2 or 3.
    function automatic logic is_err_pattern(input logic [3:0] s);
        return s[0] | (s[1] & (s[2] | s[3]));
    endfunction

endpackage

// File: rtl/debounce_counter.sv
// Debounce counter: synchronous clear has priority, otherwise counts up while
// enabled and wraps to zero after reaching the rollover value.
module debounce_counter
    import sensor_pkg::*;
(
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  clear,
    input  logic                  count_enable,
    input  logic [DBNC_CNT_W-1:0] rollover,
    output logic [DBNC_CNT_W-1:0] count
);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (count_enable) begin
            if (count == rollover) begin
                count <= '0;
            end else begin
                count <= count + 1'b1;
            end
        end
    end

endmodule

// File: rtl/sensor_monitor.sv
// Sensor monitor: synchronises four raw sensor levels, debounces the decoded
// error condition and latches an alarm until it is cleared with the error gone.
module sensor_monitor
    import sensor_pkg::*;
#(
    parameter int DEBOUNCE = 3
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   enable,
    input  logic [3:0]             sensors,
    input  logic                   clear,
    output logic                   alarm,
    output logic                   pending,
    output logic [FAULT_CNT_W-1:0] fault_count
);

    localparam logic                  SINGLE_SHOT = (DEBOUNCE == 1);
    localparam logic [DBNC_CNT_W-1:0] ROLLOVER    = DBNC_CNT_W'(DEBOUNCE - 1);

    logic [3:0]            sync_p0;
    logic [3:0]            sync_s;
    logic                  err_s;
    state_t                state;
    state_t                state_nxt;
    logic                  cnt_en;
    logic [DBNC_CNT_W-1:0] cnt;

    // Stage p0 -> s: two-flop synchroniser on the asynchronous sensor levels
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_p0 <= '0;
            sync_s  <= '0;
        end else begin
            sync_p0 <= sensors;
            sync_s  <= sync_p0;
        end
    end

    assign err_s = is_err_pattern(sync_s);

    always_comb begin
        state_nxt = state;
        cnt_en    = 1'b0;
        case (state)
            IDLE: begin
                if (enable) begin
                    state_nxt = MONITOR;
                end
            end
            MONITOR: begin
                if (!enable) begin
                    state_nxt = IDLE;
                end else if (err_s) begin
                    if (SINGLE_SHOT) begin
                        state_nxt = ALARM;
                    end else begin
                        state_nxt = PENDING;
                        cnt_en    = 1'b1;
                    end
                end
            end
            PENDING: begin
                if (!enable) begin
                    state_nxt = IDLE;
                end else if (!err_s) begin
                    state_nxt = MONITOR;
                end else if (cnt == ROLLOVER) begin
                    state_nxt = ALARM;
                end else begin
                    cnt_en = 1'b1;
                end
            end
            ALARM: begin
                // A clear is only honoured once the error has actually gone away
                if (clear && !err_s) begin
                    state_nxt = enable ? MONITOR : IDLE;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Any cycle that does not advance the debounce discards the partial count
    debounce_counter u_debounce (
        .clk          (clk),
        .rst          (rst),
        .clear        (!cnt_en),
        .count_enable (cnt_en),
        .rollover     (ROLLOVER),
        .count        (cnt)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fault_count <= '0;
        end else if ((state_nxt == ALARM) && (state != ALARM) && (fault_count != FAULT_MAX)) begin
            fault_count <= fault_count + 1'b1;
        end
    end

    assign alarm   = (state == ALARM);
    assign pending = (state == PENDING);

endmodule

// File: tb/tb_sensor_monitor.sv
// Directed bench for sensor_monitor: one instance with DEBOUNCE=3 and one with
// DEBOUNCE=1 share the stimulus; each phase checks the instance it targets.
module tb_sensor_monitor;
    import sensor_pkg::*;

    logic       clk = 1'b0;
    logic       rst;
    logic       enable;
    logic       clear;
    logic [3:0] sensors;

    logic       alarm3, pending3, alarm1, pending1;
    logic [7:0] fc3, fc1;

    int checks   = 0;
    int failures = 0;

    logic watch1     = 1'b0;
    logic pend1_seen = 1'b0;

    always #5 clk = ~clk;

    sensor_monitor #(.DEBOUNCE(3)) dut3 (
        .clk         (clk),
        .rst         (rst),
        .enable      (enable),
        .sensors     (sensors),
        .clear       (clear),
        .alarm       (alarm3),
        .pending     (pending3),
        .fault_count (fc3)
    );

    sensor_monitor #(.DEBOUNCE(1)) dut1 (
        .clk         (clk),
        .rst         (rst),
        .enable      (enable),
        .sensors     (sensors),
        .clear       (clear),
        .alarm       (alarm1),
        .pending     (pending1),
        .fault_count (fc1)
    );

    always @(negedge clk) begin
        if (watch1 && pending1) begin
            pend1_seen = 1'b1;
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    initial begin
        rst     = 1'b0;
        enable  = 1'b0;
        clear   = 1'b0;
        sensors = 4'b0000;
        #1 rst  = 1'b1;
        tick(2);
        check("rst_alarm",   32'(alarm3),   32'd0);
        check("rst_pending", 32'(pending3), 32'd0);
        check("rst_fc",      32'(fc3),      32'd0);
        check("rst_state",   32'(dut3.state), 32'(IDLE));
        rst = 1'b0;

        // Short error burst: two sampled cycles of 0001, then quiet
        enable = 1'b1;
        tick(1);
        check("en_state", 32'(dut3.state), 32'(MONITOR));
        sensors = 4'b0001;
        tick(2);
        sensors = 4'b0000;
        tick(1);
        check("burst_pend_a", 32'(pending3), 32'd1);
        tick(1);
        check("burst_pend_b", 32'(pending3), 32'd1);
        check("burst_alarm_b", 32'(alarm3), 32'd0);
        tick(1);
        check("burst_pend_c", 32'(pending3), 32'd0);
        check("burst_alarm_c", 32'(alarm3), 32'd0);
        check("burst_fc", 32'(fc3), 32'd0);

        // Held error pattern 0110: alarm after E0+4
        sensors = 4'b0110;
        tick(2);
        check("hold_pend_e1", 32'(pending3), 32'd0);
        tick(1);
        check("hold_pend_e2", 32'(pending3), 32'd1);
        tick(1);
        check("hold_pend_e3", 32'(pending3), 32'd1);
        check("hold_alarm_e3", 32'(alarm3), 32'd0);
        tick(1);
        check("hold_alarm_e4", 32'(alarm3), 32'd1);
        check("hold_pend_e4", 32'(pending3), 32'd0);
        check("hold_fc", 32'(fc3), 32'd1);
        tick(1);
        check("hold_alarm_e5", 32'(alarm3), 32'd1);

        // Clear while the error persists is ignored
        clear   = 1'b1;
        sensors = 4'b1010;
        tick(3);
        check("clr_err_alarm", 32'(alarm3), 32'd1);
        clear   = 1'b0;
        sensors = 4'b0000;
        tick(2);
        clear = 1'b1;
        tick(1);
        clear = 1'b0;
        check("clr_ok_alarm", 32'(alarm3), 32'd0);
        check("clr_ok_state", 32'(dut3.state), 32'(MONITOR));
        check("clr_ok_fc", 32'(fc3), 32'd1);

        // Alarm latched through enable=0, then cleared back to IDLE
        sensors = 4'b0001;
        tick(5);
        check("dis_alarm_on", 32'(alarm3), 32'd1);
        check("dis_fc", 32'(fc3), 32'd2);
        enable  = 1'b0;
        sensors = 4'b0000;
        tick(3);
        check("dis_alarm_held", 32'(alarm3), 32'd1);
        clear = 1'b1;
        tick(1);
        clear = 1'b0;
        check("dis_alarm_off", 32'(alarm3), 32'd0);
        check("dis_state", 32'(dut3.state), 32'(IDLE));
        sensors = 4'b0001;
        tick(6);
        check("dis_ignored_alarm", 32'(alarm3), 32'd0);
        check("dis_ignored_pend", 32'(pending3), 32'd0);
        check("dis_ignored_fc", 32'(fc3), 32'd2);
        sensors = 4'b0000;
        tick(3);

        // 256 alarm/clear rounds: fault_count saturates at 255
        enable = 1'b1;
        tick(1);
        for (int i = 0; i < 256; i++) begin
            sensors = 4'b0001;
            tick(5);
            sensors = 4'b0000;
            tick(2);
            clear = 1'b1;
            tick(1);
            clear = 1'b0;
            check("sat_fc", 32'(fc3), (i + 3 > 255) ? 32'd255 : 32'(i + 3));
        end
        check("sat_final", 32'(fc3), 32'd255);

        // Asynchronous reset mid-PENDING clears everything without a clock edge
        sensors = 4'b0001;
        tick(3);
        check("arst_pre_pend", 32'(pending3), 32'd1);
        #2 rst = 1'b1;
        #1;
        check("arst_pend", 32'(pending3), 32'd0);
        check("arst_alarm", 32'(alarm3), 32'd0);
        check("arst_fc", 32'(fc3), 32'd0);
        check("arst_fc1", 32'(fc1), 32'd0);
        check("arst_alarm1", 32'(alarm1), 32'd0);

        // DEBOUNCE=1: 1000 is benign, 0011 alarms after E0+2 with no pending
        sensors = 4'b0000;
        enable  = 1'b0;
        tick(2);
        rst    = 1'b0;
        enable = 1'b1;
        tick(1);
        watch1  = 1'b1;
        sensors = 4'b1000;
        tick(5);
        check("d1_benign_alarm", 32'(alarm1), 32'd0);
        check("d1_benign_fc", 32'(fc1), 32'd0);
        sensors = 4'b0011;
        tick(2);
        check("d1_alarm_e1", 32'(alarm1), 32'd0);
        tick(1);
        check("d1_alarm_e2", 32'(alarm1), 32'd1);
        check("d1_fc", 32'(fc1), 32'd1);
        tick(1);
        watch1 = 1'b0;
        check("d1_no_pending", 32'(pend1_seen), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/sensor_monitor.md
SENSOR_MONITOR -- requirements
Module: sensor_monitor

Interface
REQ-001 SHALL have parameter DEBOUNCE, default 3, meaning the number of consecutive error samples needed to raise the alarm; legal range 1..15.
REQ-002 SHALL have port clk  input  1  system clock; all state changes on its rising edge.
REQ-003 SHALL have port rst  input  1  reset, asynchronous, active-high.
REQ-004 SHALL have port enable  input  1  monitoring enabled when high.
REQ-005 SHALL have port sensors  input  [3:0]  raw asynchronous sensor levels.
REQ-006 SHALL have port clear  input  1  request to release a latched alarm.
REQ-007 SHALL have port alarm  output  1  latched debounced error.
REQ-008 SHALL have port pending  output  1  error seen but not yet debounced.
REQ-009 SHALL have port fault_count  output  [7:0]  number of alarm events since reset.

Function
REQ-010 SHALL pass sensors through a 2-flop synchronizer; sync_s is the second-stage value.
REQ-011 SHALL compute err_s = sync_s[0] | (sync_s[1] & (sync_s[2] | sync_s[3])), combinationally from sync_s.
REQ-012 SHALL implement FSM states IDLE, MONITOR, PENDING, ALARM, with a 4-bit debounce counter cnt.
REQ-013 IDLE: enable=1 -> MONITOR; otherwise stay; cnt=0.
REQ-014 MONITOR: enable=0 -> IDLE; err_s=1 and DEBOUNCE=1 -> ALARM; err_s=1 and DEBOUNCE>1 -> PENDING with cnt=1; else stay.
REQ-015 PENDING: enable=0 -> IDLE, cnt=0; err_s=0 -> MONITOR, cnt=0; err_s=1 and cnt=DEBOUNCE-1 -> ALARM, cnt=0; else cnt+1.
REQ-016 ALARM: stays latched regardless of enable or err_s until clear=1 is sampled with err_s=0; then -> MONITOR if enable=1, else IDLE.
REQ-017 clear SHALL be ignored in every state other than ALARM, and ignored in ALARM while err_s=1.
REQ-018 alarm SHALL be 1 exactly when state=ALARM; pending SHALL be 1 exactly when state=PENDING. Both are Moore outputs with no combinational path from inputs.
REQ-019 fault_count SHALL increment by 1 on each transition into ALARM, saturating at 255 (no wrap).
REQ-020 Latency: with sensors held in an error pattern from sampling edge E0 and the FSM in MONITOR, alarm SHALL rise after edge E0+DEBOUNCE+1.
REQ-021 A single-cycle err_s drop in PENDING SHALL restart debounce from MONITOR (cnt=0).

Reset
REQ-022 On rst=1, asynchronously: state=IDLE, cnt=0, synchronizer flops=0, alarm=0, pending=0, fault_count=0.
REQ-023 rst asserted mid-PENDING or mid-ALARM SHALL discard all progress; after release the FSM starts from IDLE.

Structure
REQ-024 A shared package sensor_pkg SHALL hold the state enum type (IDLE, MONITOR, PENDING, ALARM) and the constants FAULT_CNT_W=8 and DBNC_CNT_W=4.
REQ-025 The debounce counter SHALL be a sub-module, debounce_counter (clear, count_enable, rollover value input, 4-bit count output); the FSM, synchronizer and fault counter live in sensor_monitor.

Verification
REQ-026 Reset then enable=1, sensors=4'b0110 held 5 cycles -> err_s=1 at the synchronizer output; pending rises, alarm=1 after E0+4, fault_count=1.
REQ-027 DEBOUNCE=3, sensors=4'b0001 for 2 sampled cycles, then 4'b0000 -> pending pulses and clears; alarm stays 0; fault_count stays 0.
REQ-028 In ALARM, clear=1 while sensors=4'b1010 -> alarm stays 1; drop sensors to 0, wait 2 cycles, clear=1 -> alarm=0 next cycle, state=MONITOR.
REQ-029 In ALARM, enable=0 -> alarm stays 1; then clear=1 with err_s=0 -> state=IDLE; subsequent errors are ignored.
REQ-030 Force 256 alarm/clear cycles -> fault_count=255 and holds at 255; assert rst mid-PENDING -> all outputs 0 immediately, without waiting for a clk edge.
REQ-031 DEBOUNCE=1, sensors=4'b1000 (not an error pattern), then 4'b0011 -> no alarm for 4'b1000; alarm after E0+2 for 4'b0011, with pending never asserted.
